// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Purpose  : RV64 load/store memory stage. Turns one core memory request into
//            one 8-byte-aligned bus transaction with a byte write mask,
//            aligns and sign/zero-extends load data, and returns exactly one
//            response per request. Illegal or misaligned requests are
//            answered directly without touching the bus. A missing bus
//            response is answered with a timeout error.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_*               - core request (valid/ready handshake)
//            resp_*              - one-cycle response pulse to writeback
//            mem_req_*           - bus request (valid/ready handshake)
//            mem_resp_*          - bus read data / write acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_WAIT = 2'd2;
  localparam logic [1:0] C_ST_RESP = 2'd3;

  localparam logic [1:0] C_ERR_OK      = 2'b00;
  localparam logic [1:0] C_ERR_MISALGN = 2'b01;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] C_ERR_ILLEGAL = 2'b11;

  logic [1:0]       r_state;
  logic             r_wen;
  logic [2:0]       r_funct3;
  logic [2:0]       r_off;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic [7:0]       r_wmask;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_rdata;
  logic [1:0]       r_err;

  // Request decode (valid only while in IDLE with req_valid high)
  logic [2:0]  w_off;
  logic [1:0]  w_size;
  logic        w_illegal;
  logic        w_misal;
  logic [7:0]  w_mask;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_lane;
  logic [63:0] w_load;
  logic        w_timeout;

  assign w_off      = req_addr[2:0];
  assign w_size     = req_funct3[1:0];
  // Unsigned stores do not exist, and 111 has no size/sign meaning.
  assign w_illegal  = (req_funct3 == 3'b111) || (req_wen && req_funct3[2]);
  assign w_wdata_sh = req_wdata << {w_off, 3'b000};

  always_comb begin
    w_misal = 1'b0;
    w_mask  = 8'h00;
    case (w_size)
      2'b00: begin w_misal = 1'b0;              w_mask = 8'h01 << w_off; end
      2'b01: begin w_misal = w_off[0];          w_mask = 8'h03 << w_off; end
      2'b10: begin w_misal = (w_off[1:0] != 2'b00); w_mask = 8'h0F << w_off; end
      default: begin w_misal = (w_off != 3'b000); w_mask = 8'hFF; end
    endcase
  end

  // Load lane extraction and extension from the latched request.
  assign w_lane = mem_resp_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = 64'd0;
    case (r_funct3)
      3'b000:  w_load = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b011:  w_load = w_lane;
      3'b100:  w_load = {56'd0, w_lane[7:0]};
      3'b101:  w_load = {48'd0, w_lane[15:0]};
      3'b110:  w_load = {32'd0, w_lane[31:0]};
      default: w_load = 64'd0;
    endcase
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= C_ST_IDLE;
      r_wen    <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 3'b000;
      r_addr   <= 64'd0;
      r_wdata  <= 64'd0;
      r_wmask  <= 8'h00;
      r_cnt    <= '0;
      r_rdata  <= 64'd0;
      r_err    <= C_ERR_OK;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (req_valid) begin
            r_wen    <= req_wen;
            r_funct3 <= req_funct3;
            r_off    <= w_off;
            r_addr   <= {req_addr[63:3], 3'b000};
            r_wmask  <= req_wen ? w_mask : 8'h00;
            r_wdata  <= req_wen ? w_wdata_sh : 64'd0;
            if (w_illegal) begin
              r_state <= C_ST_RESP;
              r_err   <= C_ERR_ILLEGAL;
              r_rdata <= 64'd0;
            end else if (w_misal) begin
              r_state <= C_ST_RESP;
              r_err   <= C_ERR_MISALGN;
              r_rdata <= 64'd0;
            end else begin
              r_state <= C_ST_REQ;
            end
          end
        end
        C_ST_REQ: begin
          if (mem_req_ready) begin
            r_state <= C_ST_WAIT;
            r_cnt   <= '0;
          end
        end
        C_ST_WAIT: begin
          // A response arriving on the timeout cycle still counts as ok.
          if (mem_resp_valid) begin
            r_state <= C_ST_RESP;
            r_err   <= C_ERR_OK;
            r_rdata <= r_wen ? 64'd0 : w_load;
          end else if (w_timeout) begin
            r_state <= C_ST_RESP;
            r_err   <= C_ERR_TIMEOUT;
            r_rdata <= 64'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        C_ST_RESP: begin
          r_state <= C_ST_IDLE;
        end
        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = (r_state == C_ST_IDLE);
  assign resp_valid    = (r_state == C_ST_RESP);
  assign resp_rdata    = r_rdata;
  assign resp_err      = r_err;
  assign mem_req_valid = (r_state == C_ST_REQ);
  assign mem_req_wen   = r_wen;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Purpose  : Self-checking bench for lsu_mem_stage (TIMEOUT = 8). Directed
//            cases plus randomized requests compared against a byte-level
//            reference model of the RISC-V load/store rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  lsu_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wen        (req_wen),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One complete request. Inputs are driven and outputs sampled on negedges.
  // rdly: cycles mem_req_ready stays low; rspdly: cycles before the bus
  // response (negative = never respond, expect a timeout).
  task automatic do_op(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] mdata,
                       input int rdly, input int rspdly);
    int          sz, off, cyc, n;
    logic [1:0]  e_err;
    logic [63:0] e_rdata, e_wdata, lane, lmask;
    logic [7:0]  e_mask;

    // Reference model
    sz  = 1 << f3[1:0];
    off = int'(addr[2:0]);
    if (f3 == 3'b111 || (wen && f3 >= 3'd4)) e_err = 2'b11;
    else if (off % sz != 0)                  e_err = 2'b01;
    else                                     e_err = 2'b00;
    e_mask  = wen ? 8'(((1 << sz) - 1) << off) : 8'h00;
    e_wdata = wdata << (8 * off);
    if (wen) e_rdata = 64'd0;
    else begin
      lane = mdata >> (8 * off);
      if (sz < 8) begin
        lmask = (64'd1 << (8 * sz)) - 64'd1;
        lane  = lane & lmask;
        if (f3 < 3'd4 && lane[8*sz-1]) lane = lane | ~lmask;
      end
      e_rdata = lane;
    end

    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    cyc = 1;
    if (e_err != 2'b00) begin
      check("err_resp_valid", resp_valid, 1'b1);
      check("err_no_bus", mem_req_valid, 1'b0);
      check("err_code", resp_err, e_err);
      check("err_rdata", resp_rdata, 64'd0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        check("mreq_valid", mem_req_valid, 1'b1);
        check("mreq_req_ready", req_ready, 1'b0);
        check("mreq_wen", mem_req_wen, wen);
        check("mreq_addr", mem_req_addr, {addr[63:3], 3'b000});
        check("mreq_wmask", mem_req_wmask, e_mask);
        if (wen) check("mreq_wdata", mem_req_wdata, e_wdata);
        mem_req_ready = (i == rdly);
        @(negedge clk); cyc++;
      end
      mem_req_ready = 1'b0;
      check("wait_no_mreq", mem_req_valid, 1'b0);
      if (rspdly >= 0) begin
        for (int i = 0; i < rspdly; i++) begin
          check("wait_no_resp", resp_valid, 1'b0);
          @(negedge clk); cyc++;
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = mdata;
        @(negedge clk); cyc++;
        mem_resp_valid = 1'b0; mem_resp_rdata = {$urandom, $urandom};
        check("resp_valid", resp_valid, 1'b1);
        check("resp_err", resp_err, 2'b00);
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_latency", 64'(cyc), 64'(3 + rdly + rspdly));
      end else begin
        n = 0;
        while (!resp_valid && n < 64) begin
          @(negedge clk); n++;
        end
        check("to_resp_seen", resp_valid, 1'b1);
        check("to_err", resp_err, 2'b10);
        check("to_rdata", resp_rdata, 64'd0);
      end
    end
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
    check("back_idle", req_ready, 1'b1);
    if (rspdly < 0 && e_err == 2'b00) begin
      // Late bus response after a timeout must be ignored.
      mem_resp_valid = 1'b1; mem_resp_rdata = mdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      check("late_resp_ignored", resp_valid, 1'b0);
      check("late_idle", req_ready, 1'b1);
    end
  endtask

  initial begin
    logic        wen;
    logic [2:0]  f3;
    logic [63:0] addr;
    int          rsp;

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000;
    req_addr = 64'd0; req_wdata = 64'd0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mreq_valid", mem_req_valid, 1'b0);
    check("rst_mreq_addr", mem_req_addr, 64'd0);
    check("rst_mreq_wdata", mem_req_wdata, 64'd0);
    check("rst_mreq_wmask", mem_req_wmask, 8'h00);
    check("rst_resp_err", resp_err, 2'b00);
    check("rst_resp_rdata", resp_rdata, 64'd0);

    // Directed cases
    do_op(1'b0, 3'b011, 64'h8000_1000, 64'd0, 64'h1122334455667788, 0, 0);
    do_op(1'b0, 3'b000, 64'h8000_1005, 64'd0, 64'h0000_F000_0000_0000, 0, 0);
    do_op(1'b0, 3'b100, 64'h8000_1005, 64'd0, 64'h0000_F000_0000_0000, 0, 0);
    do_op(1'b1, 3'b001, 64'h8000_1002, 64'hABCD, 64'hDEAD_BEEF_0000_0000, 0, 0);
    do_op(1'b1, 3'b010, 64'h8000_1006, 64'h1234_5678, 64'd0, 0, 0);
    do_op(1'b0, 3'b111, 64'h8000_1000, 64'd0, 64'd0, 0, 0);
    do_op(1'b1, 3'b100, 64'h8000_1000, 64'h55, 64'd0, 0, 0);
    do_op(1'b0, 3'b010, 64'h8000_1004, 64'd0, 64'h8765_4321_0000_0000, 5, 1);
    do_op(1'b0, 3'b011, 64'h8000_2000, 64'd0, 64'hCAFE, 0, -1);
    do_op(1'b0, 3'b101, 64'h8000_2006, 64'd0, 64'h9ABC_0000_0000_0000, 0, 0);
    // A response on the last wait cycle still wins over the timeout.
    do_op(1'b0, 3'b110, 64'h8000_2004, 64'd0, 64'hF234_5678_0000_0000, 0, TIMEOUT - 1);

    // Reset while waiting for the bus response
    check("rr_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8000_3000;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_req_ready", req_ready, 1'b1);
    check("rr_resp_valid", resp_valid, 1'b0);
    check("rr_mreq_valid", mem_req_valid, 1'b0);
    check("rr_wmask", mem_req_wmask, 8'h00);
    check("rr_err", resp_err, 2'b00);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1111;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rr_inflight_ignored", resp_valid, 1'b0);
    do_op(1'b0, 3'b011, 64'h8000_3008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0);

    // Randomized requests
    for (int k = 0; k < 60; k++) begin
      wen  = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'((1 << f3[1:0]) - 1);
      rsp  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      do_op(wen, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
            int'($urandom_range(0, 3)), rsp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
